// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-outstanding request/response memory target with a fixed, parameter
//   controlled number of wait states between request accept and response.
//   Storage is 2**DEPTH_LOG2 words of 32 bits with per-byte write enables.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words (default 8 -> 256 words).
//                Must be <= 29 so the out-of-range address field exists.
//   WAIT       : wait-state cycles between accept and response (0..15).
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid / req_ready   : request handshake (ready only while idle)
//   req_we, req_addr,
//   req_wdata, req_be       : request payload (byte address, write data,
//                             byte lane enables for writes)
//   resp_valid / resp_ready : response handshake
//   resp_rdata              : read data (0 for writes, errors, and idle)
//   resp_err                : error flag
//
// Optional feature
//   MEM_ERR_EN : when defined, misaligned addresses or addresses beyond the
//                storage range are answered with resp_err=1, rdata=0 and no
//                memory access. When undefined, resp_err is tied to 0, the
//                two low address bits are ignored and addresses wrap.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_HI    = DEPTH_LOG2 + 1;
    localparam int          WORDS     = 2 ** DEPTH_LOG2;
    // Count value on which the last wait cycle ends.
    localparam logic [3:0]  WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    // IDLE / WAIT / RESP (prefixed so they cannot collide with parameter WAIT)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       enter_resp;

    // Request fields captured at accept
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  aerr_q;

    // Fields actually used for the access on the edge entering RESP
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_err;

    logic                  req_addr_err;
    logic [31:0]           rdata_q;
    logic                  rerr_q;

    logic [31:0] mem [WORDS];

    // -------------------------------------------------------------------------
    // Address checking
    // -------------------------------------------------------------------------
`ifdef MEM_ERR_EN
    assign req_addr_err = (req_addr[1:0] != 2'b00) ||
                          (req_addr[31:IDX_HI+1] != '0);
`else
    assign req_addr_err = 1'b0;
    // Byte offset and high bits are intentionally ignored (address wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IDX_HI+1], req_addr[1:0]};
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = 4'd0;
                    if (WAIT == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                // Completion edge returns to IDLE; ready only rises afterwards,
                // so no request can be taken on the completing edge.
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            aerr_q  <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[IDX_HI:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            aerr_q  <= req_addr_err;
        end
    end

    // With WAIT=0 the access happens on the accepting edge itself, so the live
    // request must be used instead of the (not yet loaded) capture registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_idx   = req_addr[IDX_HI:2];
            acc_wdata = req_wdata;
            acc_be    = req_be;
            acc_err   = req_addr_err;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_err   = aerr_q;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: no reset, contents survive reset_n. A reset during WAIT kills
    // enter_resp through the state register, so the pending write is dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    // Response registers, loaded on the edge entering RESP and held there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else if (enter_resp) begin
            if (acc_err) begin
                rdata_q <= 32'd0;
                rerr_q  <= 1'b1;
            end else if (acc_we) begin
                rdata_q <= 32'd0;
                rerr_q  <= 1'b0;
            end else begin
                rdata_q <= mem[acc_idx];
                rerr_q  <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: gated by state so they clear immediately on async reset.
    // -------------------------------------------------------------------------
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

`ifdef MEM_ERR_EN
    assign resp_err = resp_valid & rerr_q;
`else
    assign resp_err = 1'b0;
    logic unused_err;
    assign unused_err = rerr_q;
`endif

endmodule
